// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Purpose  : Synchronise a raw push-button, filter bounce over a stability
//            window, emit a clean level plus one-cycle press/release pulses.
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  logic             r_s1;
  logic             r_s2;
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             w_level_next;
  logic             w_press_next;
  logic             w_release_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_s1      <= btn_in;
      r_s2      <= r_s1;
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_level   <= w_level_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
    end
  end

  // The counter is cleared on every state entry, so it only ever counts
  // consecutive stable samples inside one wait state and cannot overrun.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (r_s2) begin
          w_state_next = ST_PRESS_WAIT;
          w_cnt_next   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!r_s2) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_next = ST_PRESSED;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + C_CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!r_s2) begin
          w_state_next = ST_RELEASE_WAIT;
          w_cnt_next   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (r_s2) begin
          w_state_next = ST_PRESSED;
          w_cnt_next   = '0;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + C_CNT_ONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Pulses decode only the accepting transitions; bounce returns are silent.
  always_comb begin
    w_level_next   = (w_state_next == ST_PRESSED) || (w_state_next == ST_RELEASE_WAIT);
    w_press_next   = (r_state == ST_PRESS_WAIT) && (w_state_next == ST_PRESSED);
    w_release_next = (r_state == ST_RELEASE_WAIT) && (w_state_next == ST_IDLE);
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debounce
// Purpose  : Directed stimulus for button_debounce checked every cycle against
//            a run-length model, plus hand-computed pulse timing checks.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_button_debounce;

  localparam int DC = 4;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level;
  logic btn_press;
  logic btn_release;

  always #5 clk = ~clk;

  button_debounce #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (16)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the accepted level flips once the synchronised input has disagreed
  // with it on DC+1 consecutive edges; any agreeing sample restarts the run.
  logic m_s1      = 1'b0;
  logic m_s2      = 1'b0;
  logic m_level   = 1'b0;
  logic m_press   = 1'b0;
  logic m_release = 1'b0;
  int   m_run     = 0;
  bit   started   = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0;
      m_press = 1'b0; m_release = 1'b0; m_run = 0;
    end else begin
      m_press   = 1'b0;
      m_release = 1'b0;
      if (m_s2 != m_level) m_run++;
      else                 m_run = 0;
      if (m_run == DC + 1) begin
        m_level   = ~m_level;
        m_press   = m_level;
        m_release = ~m_level;
        m_run     = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn_in;
    end
    started = 1'b1;
  end

  int         n_press   = 0;
  int         n_release = 0;
  logic [3:0] ds_count  = 4'd0;

  always @(negedge clk) begin
    if (started) begin
      chk("level_vs_model", btn_level, m_level);
      chk("press_vs_model", btn_press, m_press);
      chk("release_vs_model", btn_release, m_release);
      chk("press_release_exclusive", btn_press & btn_release, 1'b0);
      if (btn_press === 1'b1) begin
        n_press++;
        ds_count = ds_count + 4'd1;
      end
      if (btn_release === 1'b1) n_release++;
    end
  end

  task automatic drive(input logic b, input logic r);
    btn_in = b;
    reset  = r;
    @(posedge clk);
    #1;
  endtask

  int         p0;
  int         r0;
  logic [3:0] c0;
  logic [3:0] c_diff;

  initial begin
    @(posedge clk);
    #1;
    // Reset held with the button pressed.
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    chk("reset_level", btn_level, 1'b0);
    chk("reset_press", btn_press, 1'b0);
    chk("reset_release", btn_release, 1'b0);

    // Clean press: first non-reset edge is edge 0, pulse after edge 6.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0);
      if (i == 5) begin
        chk("press_not_early", btn_press, 1'b0);
        chk("level_not_early", btn_level, 1'b0);
      end
      if (i == 6) begin
        chk("press_at_edge6", btn_press, 1'b1);
        chk("level_at_edge6", btn_level, 1'b1);
      end
      if (i == 7) chk("press_one_cycle", btn_press, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0);
      if (i == 5) begin
        chk("release_not_early", btn_release, 1'b0);
        chk("level_held_before_release", btn_level, 1'b1);
      end
      if (i == 6) begin
        chk("release_at_edge6", btn_release, 1'b1);
        chk("level_low_at_release", btn_level, 1'b0);
      end
      if (i == 7) chk("release_one_cycle", btn_release, 1'b0);
    end
    chk_int("clean_press_count", n_press, 1);
    chk_int("clean_release_count", n_release, 1);

    // Alternating bounce must be rejected.
    p0 = n_press;
    for (int i = 0; i < 8; i++) drive((i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0);
    chk_int("bounce_no_press", n_press - p0, 0);
    chk("bounce_level_low", btn_level, 1'b0);

    // Bouncy press 1,0,1,1,...: last 0->1 sample at index 2, pulse at index 8.
    for (int i = 0; i < 14; i++) begin
      drive((i == 1) ? 1'b0 : 1'b1, 1'b0);
      if (i == 7) chk("bouncy_press_not_early", btn_press, 1'b0);
      if (i == 8) chk("bouncy_press_at_edge8", btn_press, 1'b1);
    end

    // Short release bounce while pressed.
    r0 = n_release;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0);
    chk_int("release_bounce_no_pulse", n_release - r0, 0);
    chk("release_bounce_level_high", btn_level, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0);
    chk_int("release_after_bounce", n_release - r0, 1);

    // Reset while waiting to accept a press (count at 2).
    p0 = n_press;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    chk("midpress_reset_level", btn_level, 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0);
    chk_int("midpress_reset_no_press", n_press - p0, 0);
    chk("midpress_reset_level_after", btn_level, 1'b0);

    // Reset while waiting to accept a release.
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0);
    chk("pressed_before_midrelease", btn_level, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0);
    r0 = n_release;
    drive(1'b0, 1'b1);
    chk("midrelease_reset_level", btn_level, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0);
    chk_int("midrelease_reset_no_release", n_release - r0, 0);

    // Five clean presses into a 4-bit event counter.
    c0 = ds_count;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0);
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b0);
    end
    c_diff = ds_count - c0;
    chk_int("downstream_count", int'(c_diff), 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_debounce.md
# button_debounce

Synchronous debouncer and edge-pulse generator for a raw mechanical push-button input. It synchronises the asynchronous `btn_in`, filters bounce with a programmable stability window, and produces a clean level plus single-cycle press and release pulses. It sits directly upstream of the 4-bit up counter: `btn_press` is the one-event-per-press strobe that stage consumes as its count event. The counter's `clk` is shared.

## Interface
- `DEBOUNCE_CYCLES`, default 4: number of consecutive stable synchronised samples required to accept a level change; legal range 2..65535.
- `CNT_W`, default 16: width of the internal stability counter; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset; sampled on rising `clk`.
- `btn_in`  input  1  raw, asynchronous, bouncy button level (1 = pressed).
- `btn_level`  output  1  debounced button level, registered.
- `btn_press`  output  1  one-cycle pulse on an accepted press, registered.
- `btn_release`  output  1  one-cycle pulse on an accepted release, registered.

## Operation
- Synchroniser: two flops, `s1 <= btn_in`, `s2 <= s1`. The FSM uses only `s2`.
- Stability counter `cnt` is CNT_W bits wide. It is zeroed on every state entry, increments by 1 while its wait condition holds, and never wraps.
- FSM states and transitions, evaluated each edge when `reset` = 0:
  - IDLE: if `s2` = 1, go to PRESS_WAIT with `cnt` = 0; otherwise stay.
  - PRESS_WAIT:
    - if `s2` = 0, go to IDLE (bounce rejected, no pulse);
    - else if `cnt` = DEBOUNCE_CYCLES-1, go to PRESSED;
    - else increment `cnt`.
  - PRESSED: if `s2` = 0, go to RELEASE_WAIT with `cnt` = 0; otherwise stay.
  - RELEASE_WAIT:
    - if `s2` = 1, go to PRESSED (bounce rejected, no pulse);
    - else if `cnt` = DEBOUNCE_CYCLES-1, go to IDLE;
    - else increment `cnt`.
- Outputs are registered from next-state decode:
  - `btn_level` = 1 in PRESSED and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT.
  - `btn_press` = 1 for exactly the one cycle after the PRESS_WAIT->PRESSED edge.
  - `btn_release` = 1 for exactly the one cycle after the RELEASE_WAIT->IDLE edge.
- The RELEASE_WAIT->PRESSED and PRESS_WAIT->IDLE bounce returns never generate a pulse and never change `btn_level`.
- `btn_press` and `btn_release` are never high in the same cycle. Consecutive pulses are at least DEBOUNCE_CYCLES+1 cycles apart.
- Reset (synchronous) forces:
  - state = IDLE, `cnt` = 0, `s1` = `s2` = 0;
  - `btn_level` = `btn_press` = `btn_release` = 0.
- Reset mid-operation discards any pending press or release with no pulse. A button held through reset is detected as a fresh press after reset deasserts.

## Timing
- Edge numbering: edge 0 is the first rising edge at which `btn_in` = 1 is sampled into `s1`, with `btn_in` held stable afterwards.
- Press sequence:
  - `s2` = 1 after edge 1.
  - The FSM enters PRESS_WAIT at edge 2.
  - `cnt` reaches DEBOUNCE_CYCLES-1 at edge DEBOUNCE_CYCLES+1.
  - PRESSED is entered at edge DEBOUNCE_CYCLES+2.
  - `btn_press` and `btn_level` go high after edge DEBOUNCE_CYCLES+2.
- Press latency is DEBOUNCE_CYCLES+2 cycles; for the default, the pulse appears after edge 6. Release latency is identical and is measured from the first sampled 0.
- A glitch or bounce on `btn_in` lasting fewer than DEBOUNCE_CYCLES+1 consecutive sampled cycles produces no output change.
- `btn_press` and `btn_release` are exactly one `clk` period wide.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.

1. **Reset:** assert `reset` for 2 cycles with `btn_in` = 1 -> all outputs 0 during reset. After deassertion, `btn_press` pulses once, 6 edges after the first non-reset edge.
2. **Clean press and release:** hold `btn_in` = 1 for 20 cycles, then 0 -> exactly one `btn_press` after edge 6 and `btn_level` = 1. Exactly one `btn_release` 6 edges after the first sampled 0, and `btn_level` returns to 0 at the same time.
3. **Bounce rejection:** `btn_in` toggles 1,0,1,0 each cycle for 8 cycles, then stays 0 -> no pulse and `btn_level` stays 0. Then a bouncy press (1,0,1,1,1,1,1,...) -> a single `btn_press` 6 edges after the final 0->1 sample.
4. **Release bounce:** while PRESSED, drive 0 for 3 cycles, then 1 -> no `btn_release` and `btn_level` stays 1.
5. **Reset mid-operation:** assert `reset` while in PRESS_WAIT (`cnt` = 2) -> no pulse, state IDLE. Repeat with reset asserted in RELEASE_WAIT -> `btn_level` = 0 and no `btn_release`.
6. **Downstream integration:** 5 clean presses feed the counter's event input -> the counter advances by exactly 5 (0 -> 5).
